// File: rtl/keypad_entry_if.sv
// Keypad front-end bundle: raw key pulses and selects in, assembled entry and strobes out.
// The master side drives keys; the slave side (keypad_entry) produces the entry word.
interface keypad_entry_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_enter;
  logic        key_clear;
  logic        mode_sel;
  logic [1:0]  user_sel;
  logic [11:0] InputPassword;
  logic        Enter;
  logic        SET_MODE;
  logic [1:0]  User;
  logic [1:0]  DigitCount;
  logic        EntryError;
  logic        Timeout;

  modport master (
    output key_valid, key_code, key_enter, key_clear, mode_sel, user_sel,
    input  InputPassword, Enter, SET_MODE, User, DigitCount, EntryError, Timeout
  );

  modport slave (
    input  key_valid, key_code, key_enter, key_clear, mode_sel, user_sel,
    output InputPassword, Enter, SET_MODE, User, DigitCount, EntryError, Timeout
  );
endinterface

// File: rtl/keypad_entry.sv
// Collects three hex keypresses into a 12-bit password and issues a one-cycle Enter strobe.
// Short entries are rejected, clear discards, and stale partial entries time out.
module keypad_entry #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMER_W        = 10
) (
  input  logic           clk,
  input  logic           reset,
  keypad_entry_if.slave  kp,
  output logic [1:0]     state_dbg
);

  // Handshake: key_valid/key_enter/key_clear are one-cycle pulses with no ready;
  // each is consumed (or dropped) in the cycle it is high, clear > enter > valid.
  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, FULL = 2'd2, SUBMIT = 2'd3} state_t;

  state_t              state, state_nxt;
  logic [TIMER_W-1:0]  idle_cnt;
  logic [11:0]         pw;
  logic [1:0]          digit_cnt;
  logic                set_mode_q;
  logic [1:0]          user_q;
  logic                err_q, to_q;
  logic                key_evt, timeout_hit, in_entry;
  logic                do_accept, do_clear, do_error, do_timeout, enter_o;

  assign key_evt     = kp.key_valid | kp.key_enter | kp.key_clear;
  assign in_entry    = (state == COLLECT) || (state == FULL);
  assign timeout_hit = in_entry && !key_evt && (idle_cnt == TIMER_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, COLLECT: begin
        if (kp.key_clear || kp.key_enter) state_nxt = IDLE;
        else if (kp.key_valid)            state_nxt = (digit_cnt == 2'd2) ? FULL : COLLECT;
        else if (timeout_hit)             state_nxt = IDLE;
      end
      FULL: begin
        if (kp.key_clear)      state_nxt = IDLE;
        else if (kp.key_enter) state_nxt = SUBMIT;
        else if (timeout_hit)  state_nxt = IDLE;
      end
      SUBMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    do_accept  = 1'b0;
    do_clear   = 1'b0;
    do_error   = 1'b0;
    do_timeout = 1'b0;
    enter_o    = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        do_clear   = kp.key_clear | kp.key_enter | timeout_hit;
        do_error   = !kp.key_clear && kp.key_enter;
        do_accept  = !kp.key_clear && !kp.key_enter && kp.key_valid;
        do_timeout = timeout_hit;
      end
      FULL: begin
        do_clear   = kp.key_clear | timeout_hit;
        do_error   = !kp.key_clear && !kp.key_enter && kp.key_valid;
        do_timeout = timeout_hit;
      end
      SUBMIT: begin
        // Buffer and count drop on the edge back to IDLE; mode/user are retained.
        do_clear = 1'b1;
        enter_o  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pw         <= '0;
      digit_cnt  <= '0;
      set_mode_q <= 1'b0;
      user_q     <= '0;
      err_q      <= 1'b0;
      to_q       <= 1'b0;
      idle_cnt   <= '0;
    end else begin
      err_q <= do_error;
      to_q  <= do_timeout;
      if (do_clear) begin
        pw        <= '0;
        digit_cnt <= '0;
      end else if (do_accept) begin
        pw        <= {pw[7:0], kp.key_code};
        digit_cnt <= digit_cnt + 2'd1;
        if (state == IDLE) begin
          set_mode_q <= kp.mode_sel;
          user_q     <= kp.user_sel;
        end
      end
      // Any key pulse, even an ignored one, proves the user is still present.
      if (in_entry && !key_evt && !timeout_hit) idle_cnt <= idle_cnt + 1'b1;
      else                                      idle_cnt <= '0;
    end
  end

  assign kp.InputPassword = pw;
  assign kp.Enter         = enter_o;
  assign kp.SET_MODE      = set_mode_q;
  assign kp.User          = user_q;
  assign kp.DigitCount    = digit_cnt;
  assign kp.EntryError    = err_q;
  assign kp.Timeout       = to_q;
  assign state_dbg        = state;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: hand-computed vectors checked with immediate assertions.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_keypad_entry;
  localparam int T = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] state_dbg;
  int         n_vec = 0;
  int         n_err = 0;
  int         enter_cnt = 0, err_cnt = 0, to_cnt = 0, overlap_cnt = 0;
  logic [11:0] exp_q[$];

  keypad_entry_if kif();

  keypad_entry #(.TIMEOUT_CYCLES(T), .TIMER_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .kp        (kif),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // Pulse monitor on the falling edge, midway between input changes.
  always @(negedge clk) begin
    if (kif.Enter === 1'b1) enter_cnt++;
    if (kif.EntryError === 1'b1) err_cnt++;
    if (kif.Timeout === 1'b1) to_cnt++;
    if (kif.Enter === 1'b1 && (kif.EntryError === 1'b1 || kif.Timeout === 1'b1)) overlap_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic digit(input logic [3:0] d);
    kif.key_valid = 1'b1;
    kif.key_code  = d;
    tick();
    kif.key_valid = 1'b0;
  endtask

  task automatic press_enter();
    kif.key_enter = 1'b1;
    tick();
    kif.key_enter = 1'b0;
  endtask

  task automatic press_clear();
    kif.key_clear = 1'b1;
    tick();
    kif.key_clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    kif.key_valid = 0; kif.key_code = 0; kif.key_enter = 0; kif.key_clear = 0;
    kif.mode_sel = 0;  kif.user_sel = 0;

    // Reset state
    tick(); tick();
    reset = 1'b0;
    chk("rst_pw", kif.InputPassword, 12'h000);
    chk("rst_enter", {11'd0, kif.Enter}, 12'd0);
    chk("rst_cnt", {10'd0, kif.DigitCount}, 12'd0);
    chk("rst_user", {10'd0, kif.User}, 12'd0);
    chk("rst_mode", {11'd0, kif.SET_MODE}, 12'd0);
    chk("rst_state", {10'd0, state_dbg}, 12'd0);

    // Normal 3-digit submission F,2,A
    digit(4'hF);
    chk("d1_pw", kif.InputPassword, 12'h00F);
    chk("d1_cnt", {10'd0, kif.DigitCount}, 12'd1);
    digit(4'h2);
    digit(4'hA);
    chk("full_pw", kif.InputPassword, 12'hF2A);
    chk("full_cnt", {10'd0, kif.DigitCount}, 12'd3);
    chk("full_state", {10'd0, state_dbg}, 12'd2);
    exp_q.push_back(12'hF2A);
    press_enter();
    chk("sub1_enter", {11'd0, kif.Enter}, 12'd1);
    chk("sub1_pw", kif.InputPassword, exp_q.pop_front());
    chk("sub1_mode", {11'd0, kif.SET_MODE}, 12'd0);
    chk("sub1_user", {10'd0, kif.User}, 12'd0);
    tick();
    chk("post1_enter", {11'd0, kif.Enter}, 12'd0);
    chk("post1_pw", kif.InputPassword, 12'h000);
    chk("post1_cnt", {10'd0, kif.DigitCount}, 12'd0);
    tick();
    chk("sub1_once", 12'(enter_cnt), 12'd1);

    // Short entry rejected
    digit(4'h0);
    digit(4'hA);
    press_enter();
    chk("short_err", {11'd0, kif.EntryError}, 12'd1);
    chk("short_enter", {11'd0, kif.Enter}, 12'd0);
    chk("short_cnt", {10'd0, kif.DigitCount}, 12'd0);
    chk("short_pw", kif.InputPassword, 12'h000);
    tick();
    chk("short_err_end", {11'd0, kif.EntryError}, 12'd0);

    // Fourth digit ignored with error, then submit ECE
    digit(4'hE); digit(4'hC); digit(4'hE);
    digit(4'h5);
    chk("over_err", {11'd0, kif.EntryError}, 12'd1);
    chk("over_pw", kif.InputPassword, 12'hECE);
    chk("over_cnt", {10'd0, kif.DigitCount}, 12'd3);
    exp_q.push_back(12'hECE);
    press_enter();
    chk("sub2_enter", {11'd0, kif.Enter}, 12'd1);
    chk("sub2_pw", kif.InputPassword, exp_q.pop_front());
    chk("sub2_err", {11'd0, kif.EntryError}, 12'd0);
    // Digit during SUBMIT is ignored
    digit(4'h7);
    chk("subign_cnt", {10'd0, kif.DigitCount}, 12'd0);
    chk("subign_pw", kif.InputPassword, 12'h000);
    chk("subign_err", {11'd0, kif.EntryError}, 12'd0);
    chk("subign_state", {10'd0, state_dbg}, 12'd0);

    // Mode/user latched at first digit only
    kif.mode_sel = 1'b1; kif.user_sel = 2'd2;
    digit(4'h1);
    kif.mode_sel = 1'b0; kif.user_sel = 2'd1;
    digit(4'h2); digit(4'h3);
    press_enter();
    chk("sub3_enter", {11'd0, kif.Enter}, 12'd1);
    chk("sub3_pw", kif.InputPassword, 12'h123);
    chk("sub3_mode", {11'd0, kif.SET_MODE}, 12'd1);
    chk("sub3_user", {10'd0, kif.User}, 12'd2);
    tick();
    chk("keep_mode", {11'd0, kif.SET_MODE}, 12'd1);
    chk("keep_user", {10'd0, kif.User}, 12'd2);

    // Inactivity timeout
    digit(4'h9);
    repeat (T - 1) tick();
    chk("to_early", {11'd0, kif.Timeout}, 12'd0);
    chk("to_early_cnt", {10'd0, kif.DigitCount}, 12'd1);
    tick();
    chk("to_fire", {11'd0, kif.Timeout}, 12'd1);
    chk("to_cnt", {10'd0, kif.DigitCount}, 12'd0);
    chk("to_pw", kif.InputPassword, 12'h000);
    chk("to_state", {10'd0, state_dbg}, 12'd0);
    tick();
    chk("to_end", {11'd0, kif.Timeout}, 12'd0);

    // Digit at cycle T-2 restarts the timer
    digit(4'h9);
    repeat (T - 3) tick();
    digit(4'h5);
    tick(); tick();
    chk("to_rearm", {11'd0, kif.Timeout}, 12'd0);
    chk("to_rearm_pw", kif.InputPassword, 12'h095);
    press_clear();

    // Key on the expiry cycle wins over the timeout
    digit(4'h9);
    repeat (T - 1) tick();
    digit(4'h4);
    chk("to_race", {11'd0, kif.Timeout}, 12'd0);
    chk("to_race_pw", kif.InputPassword, 12'h094);
    chk("to_race_cnt", {10'd0, kif.DigitCount}, 12'd2);
    tick();
    chk("to_race2", {11'd0, kif.Timeout}, 12'd0);
    press_clear();
    chk("to_total", 12'(to_cnt), 12'd1);

    // Clear beats enter in FULL
    digit(4'h1); digit(4'h2); digit(4'h3);
    kif.key_clear = 1'b1; kif.key_enter = 1'b1;
    tick();
    kif.key_clear = 1'b0; kif.key_enter = 1'b0;
    chk("clr_enter", {11'd0, kif.Enter}, 12'd0);
    chk("clr_err", {11'd0, kif.EntryError}, 12'd0);
    chk("clr_cnt", {10'd0, kif.DigitCount}, 12'd0);
    chk("clr_pw", kif.InputPassword, 12'h000);
    tick();
    chk("clr_enter2", {11'd0, kif.Enter}, 12'd0);

    // Reset on the key_enter cycle cancels the submission
    digit(4'h4); digit(4'h5); digit(4'h6);
    chk("pre_rst_user", {10'd0, kif.User}, 12'd1);
    kif.key_enter = 1'b1; reset = 1'b1;
    tick();
    kif.key_enter = 1'b0; reset = 1'b0;
    chk("rst2_enter", {11'd0, kif.Enter}, 12'd0);
    chk("rst2_pw", kif.InputPassword, 12'h000);
    chk("rst2_cnt", {10'd0, kif.DigitCount}, 12'd0);
    chk("rst2_user", {10'd0, kif.User}, 12'd0);
    tick();
    chk("rst2_enter2", {11'd0, kif.Enter}, 12'd0);

    chk("enter_total", 12'(enter_cnt), 12'd3);
    chk("err_total", 12'(err_cnt), 12'd2);
    chk("overlap", 12'(overlap_cnt), 12'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
Front-end stage that sits directly upstream of the `users` access/alarm block. It collects single hex keypress events into the 12-bit password word and latches the user select and set/check mode. When a complete 3-digit entry is submitted, it issues a one-cycle Enter strobe. It also rejects short entries, supports clear, and aborts stale entries on an inactivity timeout, so the downstream block only ever sees well-formed submissions.

Parameters:
- TIMEOUT_CYCLES, 1000, number of idle cycles without an accepted key event before a partial entry is discarded (must be ≥2).
- TIMER_W, 10, width of the inactivity counter (must satisfy 2^TIMER_W > TIMEOUT_CYCLES).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  one-cycle pulse: key_code holds a digit press.
- key_code  input  4  hex digit value (0x0–0xF).
- key_enter  input  1  one-cycle pulse: submit key.
- key_clear  input  1  one-cycle pulse: clear key.
- mode_sel  input  1  1 = set password, 0 = check password; sampled at first digit.
- user_sel  input  2  user index; sampled at first digit.
- InputPassword  output  12  assembled password, first digit in [11:8].
- Enter  output  1  one-cycle submit strobe to downstream.
- SET_MODE  output  1  latched mode_sel.
- User  output  2  latched user_sel.
- DigitCount  output  2  digits currently held (0–3).
- EntryError  output  1  one-cycle pulse on a rejected key.
- Timeout  output  1  one-cycle pulse on an inactivity abort.

Behaviour:
- Reset (synchronous): state IDLE; all outputs 0; inactivity counter 0.
- States:
  - IDLE: DigitCount = 0.
  - COLLECT: DigitCount 1–2.
  - FULL: DigitCount = 3.
  - SUBMIT: single cycle.
- Key priority within one cycle: key_clear > key_enter > key_valid. Lower-priority pulses in the same cycle are dropped silently.
- Digit accept (IDLE/COLLECT):
  - InputPassword <= {InputPassword[7:0], key_code}; DigitCount += 1.
  - In IDLE, also latch SET_MODE <= mode_sel and User <= user_sel.
  - The third digit moves to FULL.
  - Result visible the cycle after the key_valid cycle.
- Digit in FULL: ignored; buffer unchanged; EntryError pulses next cycle; inactivity counter resets.
- key_enter in FULL: next cycle is SUBMIT.
  - Enter = 1 for exactly that cycle.
  - InputPassword, SET_MODE and User are stable during that cycle.
  - The following cycle returns to IDLE with InputPassword = 0 and DigitCount = 0.
  - SET_MODE and User keep their latched values until the next first digit.
- key_enter in IDLE/COLLECT: EntryError pulses; buffer cleared; DigitCount = 0; IDLE; Enter stays 0.
- key_clear in IDLE/COLLECT/FULL: buffer cleared; DigitCount = 0; IDLE; no EntryError.
- SUBMIT: all key inputs ignored (no error, no accept).
- Inactivity:
  - Counter runs only in COLLECT/FULL.
  - Increments each cycle with no key_valid/key_enter/key_clear pulse; resets to 0 on any such pulse (including an ignored digit in FULL) and in IDLE/SUBMIT.
  - When the counter reaches TIMEOUT_CYCLES−1, the next cycle clears the buffer, enters IDLE, and pulses Timeout.
  - A key event arriving on that same cycle takes precedence and the timeout does not fire.
- EntryError and Timeout are never high simultaneously with Enter.
- Enter is never asserted twice without an intervening IDLE.
- Reset asserted mid-entry or during SUBMIT: the next cycle is IDLE with all outputs 0. A pending Enter is cancelled.
- Latency: key_enter on cycle N -> Enter on cycle N+1.

Test Plan:
- Reset, mode_sel = 0, user_sel = 0, digits F, 2, A, then key_enter -> InputPassword = 12'hF2A, SET_MODE = 0, User = 0, Enter high exactly 1 cycle. Afterwards DigitCount = 0 and InputPassword = 0.
- Digits 0, A, key_enter -> EntryError one pulse, Enter never asserted, DigitCount = 0.
- Digits E, C, E, then fourth digit 5, then key_enter -> EntryError on the 5, Enter with InputPassword = 12'hECE.
- mode_sel = 1, user_sel = 2 on first digit, then flip both before submit -> Enter with SET_MODE = 1, User = 2.
- Digit 9, then idle TIMEOUT_CYCLES cycles -> Timeout one pulse, DigitCount = 0. Repeat with a digit at cycle TIMEOUT_CYCLES−2 -> no Timeout.
- key_clear and key_enter in the same cycle in FULL -> IDLE, no Enter, no EntryError. Reset pulsed on the key_enter cycle -> no Enter.
